target_lut_ctrl: RTL and testbench

- Writable branch-target table with a boot-time load sequencer.
- On Start, the FSM fetches NUM_ENTRIES 8-bit target addresses from data memory into a 32-entry register table.
- Instruction decode then looks up targets by 5-bit key.
- Arbitrates table writes between the loader (priority) and runtime CPU writes; flags dropped writes.

---
 rtl/target_lut_ctrl_if.sv | 30 +++
 rtl/target_lut_ctrl.sv | 122 ++++++++++++
 tb/tb_target_lut_ctrl.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/target_lut_ctrl_if.sv
// Handshake bundle for target_lut_ctrl: load control, data-memory read port,
// lookup port and runtime write port. slave = the controller, master = its environment.
interface target_lut_ctrl_if #(
   parameter int KEYW = 5,
   parameter int AW   = 8
);
   logic            Start;
   logic            mem_rd_en;
   logic [AW-1:0]   mem_addr;
   logic [AW-1:0]   mem_rd_data;
   logic            mem_rd_valid;
   logic [KEYW-1:0] key;
   logic [AW-1:0]   LUTaddr;
   logic            wr_en;
   logic [KEYW-1:0] wr_key;
   logic [AW-1:0]   wr_data;
   logic            busy;
   logic            ready;
   logic            wr_err;

   modport slave (
      input  Start, mem_rd_data, mem_rd_valid, key, wr_en, wr_key, wr_data,
      output mem_rd_en, mem_addr, LUTaddr, busy, ready, wr_err
   );

   modport master (
      output Start, mem_rd_data, mem_rd_valid, key, wr_en, wr_key, wr_data,
      input  mem_rd_en, mem_addr, LUTaddr, busy, ready, wr_err
   );
endinterface

// File: rtl/target_lut_ctrl.sv
// Branch-target table with a boot-time loader that fetches NUM_ENTRIES targets from data memory.
// Optional macro LUT_DEFAULT_ROM_EN: reset preloads a default image and marks the table ready.
module target_lut_ctrl #(
   parameter int              KEYW        = 5,
   parameter int              AW          = 8,
   parameter int              NUM_ENTRIES = 18,
   parameter logic [AW-1:0]   BASE_ADDR   = '0
) (
   input  logic               Clk,
   input  logic               Reset,
   target_lut_ctrl_if.slave   bus
);

   localparam int              DEPTH    = 2**KEYW;
   localparam logic [KEYW:0]   NUM_E    = (KEYW+1)'(NUM_ENTRIES);
   localparam logic [KEYW-1:0] LAST_IDX = KEYW'(NUM_ENTRIES - 1);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

   state_e          state_q, state_d;
   logic [KEYW-1:0] idx_q, idx_d;
   logic            ready_q, ready_d;
   logic            wr_err_q, wr_err_d;
   logic [AW-1:0]   tbl_q [DEPTH];
   logic            ld_we, rt_we;
   logic            start_acc;

`ifdef LUT_DEFAULT_ROM_EN
   function automatic logic [AW-1:0] rom_entry(input int i);
      logic [7:0] v;
      case (i)
         0:  v = 8'd32;   1:  v = 8'd33;   2:  v = 8'd34;   3:  v = 8'd35;
         4:  v = 8'd60;   5:  v = 8'd64;   6:  v = 8'd91;   7:  v = 8'd109;
         8:  v = 8'd128;  9:  v = 8'd142;  10: v = 8'd168;  11: v = 8'd170;
         12: v = 8'd200;  13: v = 8'd204;  14: v = 8'd224;  15: v = 8'd232;
         16: v = 8'd240;  17: v = 8'd254;
         default: v = 8'd0;
      endcase
      // Keys beyond the loadable range must read as zero forever.
      return (i < NUM_ENTRIES) ? AW'(v) : '0;
   endfunction
`endif

   assign start_acc = (state_q == IDLE) && bus.Start;

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      ready_d  = ready_q;
      wr_err_d = 1'b0;
      ld_we    = 1'b0;
      rt_we    = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.Start) begin
               idx_d   = '0;
               ready_d = 1'b0;
               state_d = REQ;
            end
         end
         REQ:  state_d = WAIT;
         WAIT: begin
            if (bus.mem_rd_valid) begin
               ld_we = 1'b1;
               if (idx_q == LAST_IDX) begin
                  state_d = DONE;
               end else begin
                  idx_d   = idx_q + 1'b1;
                  state_d = REQ;
               end
            end
         end
         DONE: begin
            ready_d = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Loader owns the table from the accepting Start until it is back in IDLE.
      if (bus.wr_en) begin
         if (start_acc || (state_q != IDLE) || !ready_q) begin
            wr_err_d = 1'b1;
         end else if ({1'b0, bus.wr_key} < NUM_E) begin
            rt_we = 1'b1;
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         wr_err_q <= 1'b0;
`ifdef LUT_DEFAULT_ROM_EN
         ready_q  <= 1'b1;
         for (int i = 0; i < DEPTH; i++) tbl_q[i] <= rom_entry(i);
`else
         ready_q  <= 1'b0;
         for (int i = 0; i < DEPTH; i++) tbl_q[i] <= '0;
`endif
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         ready_q  <= ready_d;
         wr_err_q <= wr_err_d;
         if (ld_we) begin
            tbl_q[idx_q] <= bus.mem_rd_data;
         end else if (rt_we) begin
            tbl_q[bus.wr_key] <= bus.wr_data;
         end
      end
   end

   assign bus.busy      = (state_q != IDLE);
   assign bus.ready     = ready_q;
   assign bus.wr_err    = wr_err_q;
   assign bus.mem_rd_en = (state_q == REQ);
   assign bus.mem_addr  = (state_q == REQ) ? (BASE_ADDR + AW'(idx_q)) : '0;
   assign bus.LUTaddr   = (ready_q && ({1'b0, bus.key} < NUM_E)) ? tbl_q[bus.key] : '0;

endmodule

// File: tb/tb_target_lut_ctrl.sv
// Bench for target_lut_ctrl: two instances (base 0 / latency 1, base 250 / latency 3),
// a latency-configurable memory responder and a table-level reference model.
module tb_target_lut_ctrl;
   localparam int KEYW = 5;
   localparam int AW   = 8;
   localparam int N    = 18;

   logic Clk;
   logic rst [2];

   logic       start [2], wr_en [2], rd_valid [2];
   logic [4:0] key [2], wr_key [2];
   logic [7:0] wr_data [2], rd_data [2];
   logic       busy_o [2], ready_o [2], err_o [2], en_o [2];
   logic [7:0] addr_o [2], lut_o [2];

   target_lut_ctrl_if #(.KEYW(KEYW), .AW(AW)) bus0 ();
   target_lut_ctrl_if #(.KEYW(KEYW), .AW(AW)) bus1 ();

   target_lut_ctrl #(.KEYW(KEYW), .AW(AW), .NUM_ENTRIES(N), .BASE_ADDR(8'd0))
      u0 (.Clk(Clk), .Reset(rst[0]), .bus(bus0));
   target_lut_ctrl #(.KEYW(KEYW), .AW(AW), .NUM_ENTRIES(N), .BASE_ADDR(8'd250))
      u1 (.Clk(Clk), .Reset(rst[1]), .bus(bus1));

   assign bus0.Start = start[0];       assign bus1.Start = start[1];
   assign bus0.wr_en = wr_en[0];       assign bus1.wr_en = wr_en[1];
   assign bus0.wr_key = wr_key[0];     assign bus1.wr_key = wr_key[1];
   assign bus0.wr_data = wr_data[0];   assign bus1.wr_data = wr_data[1];
   assign bus0.key = key[0];           assign bus1.key = key[1];
   assign bus0.mem_rd_data = rd_data[0];   assign bus1.mem_rd_data = rd_data[1];
   assign bus0.mem_rd_valid = rd_valid[0]; assign bus1.mem_rd_valid = rd_valid[1];
   assign busy_o[0] = bus0.busy;       assign busy_o[1] = bus1.busy;
   assign ready_o[0] = bus0.ready;     assign ready_o[1] = bus1.ready;
   assign err_o[0] = bus0.wr_err;      assign err_o[1] = bus1.wr_err;
   assign en_o[0] = bus0.mem_rd_en;    assign en_o[1] = bus1.mem_rd_en;
   assign addr_o[0] = bus0.mem_addr;   assign addr_o[1] = bus1.mem_addr;
   assign lut_o[0] = bus0.LUTaddr;     assign lut_o[1] = bus1.LUTaddr;

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   // memory environment settings and reference model
   logic [7:0] base [2];
   logic [7:0] mask [2];
   int         lat [2];
   logic [7:0] mtab [2][32];
   bit         mready [2];
   logic [7:0] rom_img [18];

   // responder bookkeeping
   int         pend [2];
   logic [7:0] paddr [2];
   bit         prev_en [2];
   int         req_cnt [2];
   int         en_long [2];
   logic [7:0] addr_log [2][64];

   int total = 0;
   int bad   = 0;

   // Memory answers each request lat[d] cycles later with addr ^ mask[d] for one cycle.
   initial begin
      for (int d = 0; d < 2; d++) begin
         pend[d] = 0; prev_en[d] = 0; req_cnt[d] = 0; en_long[d] = 0;
         rd_valid[d] = 1'b0; rd_data[d] = 8'h00; paddr[d] = 8'h00;
      end
      forever begin
         @(negedge Clk);
         for (int d = 0; d < 2; d++) begin
            rd_valid[d] = 1'b0;
            if (pend[d] > 0) begin
               pend[d]--;
               if (pend[d] == 0) begin
                  rd_valid[d] = 1'b1;
                  rd_data[d]  = paddr[d] ^ mask[d];
               end
            end
            if (en_o[d] === 1'b1) begin
               if (prev_en[d]) en_long[d]++;
               if (req_cnt[d] < 64) addr_log[d][req_cnt[d]] = addr_o[d];
               req_cnt[d]++;
               paddr[d] = addr_o[d];
               pend[d]  = lat[d];
            end
            prev_en[d] = (en_o[d] === 1'b1);
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge Clk);
      #1;
   endtask

   function automatic logic [7:0] exp_lut(input int d, input int k);
      return (mready[d] && k < N) ? mtab[d][k] : 8'h00;
   endfunction

   task automatic model_reset(input int d);
      for (int i = 0; i < 32; i++) begin
`ifdef LUT_DEFAULT_ROM_EN
         mtab[d][i] = (i < N) ? rom_img[i] : 8'h00;
`else
         mtab[d][i] = 8'h00;
`endif
      end
`ifdef LUT_DEFAULT_ROM_EN
      mready[d] = 1'b1;
`else
      mready[d] = 1'b0;
`endif
   endtask

   task automatic model_load(input int d);
      for (int i = 0; i < 32; i++)
         mtab[d][i] = (i < N) ? (8'(base[d] + 8'(i)) ^ mask[d]) : 8'h00;
      mready[d] = 1'b1;
   endtask

   task automatic sweep(input int d, input string tag);
      for (int k = 0; k < 32; k++) begin
         tick();
         key[d] = 5'(k);
         #1;
         check($sformatf("%s_k%0d", tag, k), 32'(lut_o[d]), 32'(exp_lut(d, k)));
      end
   endtask

   task automatic rt_write(input int d, input logic [4:0] k, input logic [7:0] v, input string tag);
      bit experr;
      experr = !mready[d];
      if (!experr && k < N) mtab[d][k] = v;
      tick();
      wr_en[d] = 1'b1; wr_key[d] = k; wr_data[d] = v;
      tick();
      wr_en[d] = 1'b0;
      check({tag, "_err"}, 32'(err_o[d]), 32'(experr));
      key[d] = k;
      #1;
      check({tag, "_rd"}, 32'(lut_o[d]), 32'(exp_lut(d, int'(k))));
      tick();
      check({tag, "_errfall"}, 32'(err_o[d]), 32'd0);
   endtask

   task automatic load(input int d, input bit wr_at_start, input int mid_wr,
                       input int exp_busy, input string tag);
      int bc, errs, t0, exp_errs, el0;
      t0  = req_cnt[d];
      el0 = en_long[d];
      exp_errs = (wr_at_start ? 1 : 0) + ((mid_wr >= 0) ? 1 : 0);
      tick();
      start[d] = 1'b1;
      if (wr_at_start) begin
         wr_en[d] = 1'b1; wr_key[d] = 5'($urandom_range(0, N-1)); wr_data[d] = 8'($urandom);
      end
      tick();
      start[d] = 1'b0; wr_en[d] = 1'b0;
      check({tag, "_ready_drop"}, 32'(ready_o[d]), 32'd0);
      bc = 0; errs = 0;
      for (int c = 0; c < 400 && busy_o[d] === 1'b1; c++) begin
         bc++;
         if (err_o[d] === 1'b1) errs++;
         if (c == mid_wr) begin
            wr_en[d] = 1'b1; wr_key[d] = 5'($urandom_range(0, N-1)); wr_data[d] = 8'($urandom);
         end else begin
            wr_en[d] = 1'b0;
         end
         tick();
      end
      wr_en[d] = 1'b0;
      check({tag, "_busy_cycles"}, 32'(bc), 32'(exp_busy));
      check({tag, "_wr_err_pulses"}, 32'(errs), 32'(exp_errs));
      check({tag, "_ready"}, 32'(ready_o[d]), 32'd1);
      check({tag, "_req_count"}, 32'(req_cnt[d] - t0), 32'(N));
      check({tag, "_en_one_cycle"}, 32'(en_long[d] - el0), 32'd0);
      for (int i = 0; i < N; i++)
         check($sformatf("%s_addr%0d", tag, i), 32'(addr_log[d][t0 + i]), 32'(8'(base[d] + 8'(i))));
      model_load(d);
   endtask

   initial begin
      int t0, en_seen;
      rom_img = '{8'd32, 8'd33, 8'd34, 8'd35, 8'd60, 8'd64, 8'd91, 8'd109, 8'd128,
                  8'd142, 8'd168, 8'd170, 8'd200, 8'd204, 8'd224, 8'd232, 8'd240, 8'd254};
      base[0] = 8'd0;   base[1] = 8'd250;
      lat[0]  = 1;      lat[1]  = 3;
      mask[0] = 8'h5A;  mask[1] = 8'h5A;
      for (int d = 0; d < 2; d++) begin
         start[d] = 1'b0; wr_en[d] = 1'b0; key[d] = 5'd0; wr_key[d] = 5'd0; wr_data[d] = 8'd0;
         rst[d] = 1'b1;
      end
      repeat (3) tick();
      rst[0] = 1'b0; rst[1] = 1'b0;
      model_reset(0); model_reset(1);

      // reset state
      for (int d = 0; d < 2; d++) begin
         check($sformatf("rst_busy%0d", d), 32'(busy_o[d]), 32'd0);
         check($sformatf("rst_ready%0d", d), 32'(ready_o[d]), 32'(mready[d]));
         check($sformatf("rst_en%0d", d), 32'(en_o[d]), 32'd0);
         check($sformatf("rst_addr%0d", d), 32'(addr_o[d]), 32'd0);
         check($sformatf("rst_err%0d", d), 32'(err_o[d]), 32'd0);
      end
      key[0] = 5'd17; #1;
`ifdef LUT_DEFAULT_ROM_EN
      check("rst_key17", 32'(lut_o[0]), 32'd254);
      key[0] = 5'd4; #1;
      check("rst_key4", 32'(lut_o[0]), 32'd60);
`else
      check("rst_key17", 32'(lut_o[0]), 32'd0);
`endif
      sweep(0, "rst");
      check("no_traffic0", 32'(req_cnt[0]), 32'd0);
      check("no_traffic1", 32'(req_cnt[1]), 32'd0);

      // first load, base 0, one-cycle memory
      load(0, 1'b0, -1, 2*N+1, "ld0");
      key[0] = 5'd5;  #1; check("ld0_key5", 32'(lut_o[0]), 32'h5F);
      key[0] = 5'd20; #1; check("ld0_key20", 32'(lut_o[0]), 32'h00);
      sweep(0, "ld0");

      // runtime writes
      rt_write(0, 5'd3, 8'hAB, "wr3");
      rt_write(0, 5'd18, 8'h11, "wr18");
      sweep(0, "after_wr");
      repeat (12) rt_write(0, 5'($urandom_range(0, 31)), 8'($urandom), "rnd_wr");

      // reload with new contents; writes at Start and mid-load must be dropped
      mask[0] = 8'($urandom);
      load(0, 1'b1, int'($urandom_range(3, 20)), 2*N+1, "reload");
      sweep(0, "reload");

      // wrapping base address, slow memory
      load(1, 1'b0, -1, 4*N+1, "ld1");
      sweep(1, "ld1");

      // abort a load in WAIT at idx 7; the pending response lands after reset
      lat[0] = 3; mask[0] = 8'h3C;
      t0 = req_cnt[0];
      tick(); start[0] = 1'b1;
      tick(); start[0] = 1'b0;
      for (int c = 0; c < 400 && (req_cnt[0] - t0) < 8; c++) tick();
      check("abort_reached_idx7", 32'(req_cnt[0] - t0), 32'd8);
      tick();
      rst[0] = 1'b1;
      tick();
      rst[0] = 1'b0;
      model_reset(0);
      check("abort_busy", 32'(busy_o[0]), 32'd0);
      check("abort_ready", 32'(ready_o[0]), 32'(mready[0]));
      check("abort_en", 32'(en_o[0]), 32'd0);
      en_seen = 0;
      repeat (6) begin
         tick();
         if (en_o[0] !== 1'b0 || busy_o[0] !== 1'b0) en_seen++;
      end
      check("abort_quiet", 32'(en_seen), 32'd0);
      check("abort_req_count", 32'(req_cnt[0] - t0), 32'd8);
      sweep(0, "abort");
      rt_write(0, 5'd3, 8'h77, "wr_after_abort");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
